// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
//   Shared types, default 640x480@60 raster geometry and helpers for the
//   VGA timing generator slice.
//   No ports (package).
// -----------------------------------------------------------------------------
package vga_timing_pkg;

    // Default raster geometry for 640x480@60 on a 25 MHz pixel clock.
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    // Coordinates are 10 bits wide, so neither axis may exceed this many positions.
    localparam int MAX_TOTAL = 1024;

    typedef logic [9:0]  coord_t;
    typedef logic [15:0] frame_cnt_t;

    function automatic int h_total(input int visible, input int front,
                                   input int sync, input int back);
        return visible + front + sync + back;
    endfunction

    function automatic int v_total(input int visible, input int front,
                                   input int sync, input int back);
        return visible + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// -----------------------------------------------------------------------------
// vga_timing_if
//   Raster bus from the timing generator to the renderers.
//   DrawX/DrawY  : current pixel position
//   hs/vs        : sync pulses
//   blank        : 1 = active (visible) pixel
//   line_start   : one-cycle strobe at DrawX==0
//   frame_start  : one-cycle strobe at (0,0)
//   frame_count  : completed-frame-start counter
//   master = generator side, slave = consumer side.
// -----------------------------------------------------------------------------
interface vga_timing_if;
    import vga_timing_pkg::*;

    coord_t     DrawX;
    coord_t     DrawY;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       line_start;
    logic       frame_start;
    frame_cnt_t frame_count;

    modport master (
        output DrawX, DrawY, hs, vs, blank, line_start, frame_start, frame_count
    );

    modport slave (
        input DrawX, DrawY, hs, vs, blank, line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
//   Position counter for one raster axis, counting 0..TOTAL-1 and wrapping.
//   clk        in  : pixel clock
//   rst        in  : asynchronous active-high reset
//   inc        in  : advance by one this cycle
//   clear      in  : force the next position to 0 (takes priority over inc)
//   count      out : current (registered) position
//   next_count out : position that will be loaded on the coming edge
//   wrap       out : the coming edge moves TOTAL-1 -> 0 under inc
// -----------------------------------------------------------------------------
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL = 800
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   inc,
    input  logic   clear,
    output coord_t count,
    output coord_t next_count,
    output logic   wrap
);

    localparam coord_t LAST = coord_t'(TOTAL - 1);

    coord_t r_count;

    always_comb begin
        next_count = r_count;
        if (clear) begin
            next_count = '0;
        end else if (inc) begin
            next_count = (r_count == LAST) ? '0 : r_count + 1'b1;
        end
    end

    assign wrap  = inc && (next_count == '0);
    assign count = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= next_count;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Free-running raster timing source. Counts pixel/line positions, decodes
//   hsync/vsync/blank and produces line/frame strobes plus a frame counter.
//   vga_clk in  : pixel clock, all state on the rising edge
//   reset   in  : asynchronous active-high reset
//   vga     out : vga_timing_if.master (DrawX, DrawY, hs, vs, blank,
//                 line_start, frame_start, frame_count)
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_VISIBLE   = DEF_H_VISIBLE,
    parameter int   H_FRONT     = DEF_H_FRONT,
    parameter int   H_SYNC      = DEF_H_SYNC,
    parameter int   H_BACK      = DEF_H_BACK,
    parameter int   V_VISIBLE   = DEF_V_VISIBLE,
    parameter int   V_FRONT     = DEF_V_FRONT,
    parameter int   V_SYNC      = DEF_V_SYNC,
    parameter int   V_BACK      = DEF_V_BACK,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic          vga_clk,
    input  logic          reset,
    vga_timing_if.master  vga
);

    localparam int H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    if (H_TOTAL > MAX_TOTAL) begin : g_h_total_chk
        $error("vga_timing_gen: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > MAX_TOTAL) begin : g_v_total_chk
        $error("vga_timing_gen: V_TOTAL exceeds 1024");
    end

    // Decode bounds are one bit wider than a coordinate so an end bound of
    // exactly 1024 does not truncate to 0.
    localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
    localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
    localparam logic [10:0] VS_START   = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END     = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic       r_started;
    logic       r_hs;
    logic       r_vs;
    logic       r_blank;
    logic       r_line_start;
    logic       r_frame_start;
    frame_cnt_t r_frame_count;

    coord_t     w_h_count;
    coord_t     w_h_next;
    logic       w_h_wrap;
    coord_t     w_v_count;
    coord_t     w_v_next;
    logic       w_v_wrap;
    logic [10:0] w_h_wide;
    logic [10:0] w_v_wide;
    logic       w_hs_on;
    logic       w_vs_on;
    logic       w_visible;

    // The first edge after reset only sets r_started: the position holds at
    // the origin so (0,0) is presented for a full cycle with its decode.
    vga_axis_counter #(.TOTAL(H_TOTAL)) u_h_counter (
        .clk        (vga_clk),
        .rst        (reset),
        .inc        (r_started),
        .clear      (~r_started),
        .count      (w_h_count),
        .next_count (w_h_next),
        .wrap       (w_h_wrap)
    );

    vga_axis_counter #(.TOTAL(V_TOTAL)) u_v_counter (
        .clk        (vga_clk),
        .rst        (reset),
        .inc        (w_h_wrap),
        .clear      (~r_started),
        .count      (w_v_count),
        .next_count (w_v_next),
        .wrap       (w_v_wrap)
    );

    // Decode the position being loaded this edge so the registered outputs
    // line up with the registered counters at the ports.
    assign w_h_wide  = {1'b0, w_h_next};
    assign w_v_wide  = {1'b0, w_v_next};
    assign w_hs_on   = (w_h_wide >= HS_START) && (w_h_wide < HS_END);
    assign w_vs_on   = (w_v_wide >= VS_START) && (w_v_wide < VS_END);
    assign w_visible = (w_h_wide < H_VIS_END) && (w_v_wide < V_VIS_END);

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_started     <= 1'b0;
            r_hs          <= ~SYNC_ACTIVE;
            r_vs          <= ~SYNC_ACTIVE;
            r_blank       <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_started     <= 1'b1;
            r_hs          <= w_hs_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_vs          <= w_vs_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_blank       <= w_visible;
            r_line_start  <= (w_h_next == '0);
            r_frame_start <= (w_h_next == '0) && (w_v_next == '0);
            // Only a real (799,524)->(0,0) wrap counts; the post-reset
            // frame_start does not.
            if (w_v_wrap) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    assign vga.DrawX       = w_h_count;
    assign vga.DrawY       = w_v_count;
    assign vga.hs          = r_hs;
    assign vga.vs          = r_vs;
    assign vga.blank       = r_blank;
    assign vga.line_start  = r_line_start;
    assign vga.frame_start = r_frame_start;
    assign vga.frame_count = r_frame_count;

endmodule
